uart_fw_cmd_decoder: RTL



---
 rtl/uart_fw_pkg.sv | 34 +++
 rtl/uart_fw_cmd_decoder_if.sv | 36 +++
 rtl/uart_fw_byte_shifter.sv | 46 ++++
 rtl/uart_fw_cmd_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_fw_pkg.sv
// ----------------------------------------------------------------------------
// uart_fw_pkg
// Shared definitions for the UART flash-programming command path:
//   - host frame opcodes (write / read)
//   - command decoder state encoding
//   - flash-writer register bank offsets
// ----------------------------------------------------------------------------
package uart_fw_pkg;

    // Host frame opcodes
    localparam logic [7:0] OPC_WR = 8'hA3;
    localparam logic [7:0] OPC_RD = 8'hA5;

    // Command decoder states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_READ,
        ST_CAPT,
        ST_RESP
    } state_t;

    // Flash-writer register bank offsets
    localparam logic [31:0] REG_WE  = 32'h0000_0000;
    localparam logic [31:0] REG_SS  = 32'h0000_0004;
    localparam logic [31:0] REG_SCK = 32'h0000_0008;
    localparam logic [31:0] REG_OE  = 32'h0000_000C;
    localparam logic [31:0] REG_SO  = 32'h0000_0010;
    localparam logic [31:0] REG_SI  = 32'h0000_0014;
    localparam logic [31:0] REG_ID  = 32'h0000_0018;

endpackage

// File: rtl/uart_fw_cmd_decoder_if.sv
// ----------------------------------------------------------------------------
// uart_fw_cmd_decoder_if
// Groups the UART byte streams and the register-bank bus seen by the command
// decoder.
//   rx_data/rx_valid       : received byte strobe (no backpressure)
//   tx_data/tx_valid/ready : byte to transmit, valid/ready handshake
//   bus_addr/wdata/we/re   : register write/read request
//   bus_rdata              : read data, valid the cycle after bus_re
// Modports:
//   master : the decoder (consumes rx, drives tx and bus requests)
//   slave  : the surrounding UART + register bank
// ----------------------------------------------------------------------------
interface uart_fw_cmd_decoder_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;

    modport master (
        input  rx_data, rx_valid, tx_ready, bus_rdata,
        output tx_data, tx_valid, bus_addr, bus_wdata, bus_we, bus_re
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, bus_rdata,
        input  tx_data, tx_valid, bus_addr, bus_wdata, bus_we, bus_re
    );

endinterface

// File: rtl/uart_fw_byte_shifter.sv
// ----------------------------------------------------------------------------
// uart_fw_byte_shifter
// 4-byte LSB-first shift register with a 2-bit byte counter.
// Shifting moves a new byte into the top and drops the bottom byte, so after
// four shifts the first byte sits in word[7:0]; word[7:0] is also the next
// byte to send when used as a transmit serializer.
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   clr           : clear byte counter
//   shift         : shift shift_in into the top byte, advance counter
//   load          : parallel load of load_word, clears counter (wins over shift)
//   shift_in      : byte entering at word[31:24]
//   load_word     : parallel load value
//   word          : current contents
//   cnt           : bytes shifted since last clear/load (wraps after 3)
// ----------------------------------------------------------------------------
module uart_fw_byte_shifter (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        clr,
    input  logic        shift,
    input  logic        load,
    input  logic [7:0]  shift_in,
    input  logic [31:0] load_word,
    output logic [31:0] word,
    output logic [1:0]  cnt
);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            word <= '0;
            cnt  <= '0;
        end else begin
            if (load)
                word <= load_word;
            else if (shift)
                word <= {shift_in, word[31:8]};

            if (clr || load)
                cnt <= '0;
            else if (shift)
                cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/uart_fw_cmd_decoder.sv
// ----------------------------------------------------------------------------
// uart_fw_cmd_decoder
// Assembles host frames from UART bytes and issues single-word register
// writes/reads to the flash-writer register bank. Read results are returned
// to the UART transmitter least significant byte first.
//   Write frame: OP_WR a0 a1 a2 a3 d0 d1 d2 d3
//   Read  frame: OP_RD a0 a1 a2 a3  -> response r0 r1 r2 r3
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   host          : rx/tx byte streams and register bus (master modport)
//   frame_err     : one-cycle pulse on a protocol error (bad opcode, byte
//                   dropped while busy, inter-byte timeout)
//   busy          : high whenever a frame is in progress
// Build option:
//   UART_FW_TIMEOUT_EN : abort a partial frame after TIMEOUT_CYCLES idle
//                        cycles between address/data bytes
// ----------------------------------------------------------------------------
module uart_fw_cmd_decoder
    import uart_fw_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter logic [7:0]  OP_WR          = OPC_WR,
    parameter logic [7:0]  OP_RD          = OPC_RD
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    uart_fw_cmd_decoder_if.master host,
    output logic                  frame_err,
    output logic                  busy
);

    state_t      state, state_n;
    logic        op_rd;
    logic [31:0] bus_addr_q, bus_wdata_q;

    logic        rx_shift, tx_shift, tx_load, seq_clr;
    logic        op_ld, addr_ld, wdata_ld;
    logic        tx_valid, bus_we, bus_re;
    logic        timeout;
    logic [31:0] rx_word, tx_word;
    logic [1:0]  rx_cnt, tx_cnt;

    // Only the upper bytes of the rx word and the low byte of the tx word
    // are consumed here.
    logic [7:0]  rx_lsb_unused;
    logic [23:0] tx_msb_unused;
    assign rx_lsb_unused = rx_word[7:0];
    assign tx_msb_unused = tx_word[31:8];

    uart_fw_byte_shifter u_rx_shift (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .clr       (seq_clr),
        .shift     (rx_shift),
        .load      (1'b0),
        .shift_in  (host.rx_data),
        .load_word ('0),
        .word      (rx_word),
        .cnt       (rx_cnt)
    );

    uart_fw_byte_shifter u_tx_shift (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .clr       (seq_clr),
        .shift     (tx_shift),
        .load      (tx_load),
        .shift_in  (8'h00),
        .load_word (host.bus_rdata),
        .word      (tx_word),
        .cnt       (tx_cnt)
    );

`ifdef UART_FW_TIMEOUT_EN
    logic        in_frame;
    logic [31:0] gap_cnt;

    assign in_frame = (state == ST_ADDR) || (state == ST_DATA);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            gap_cnt <= '0;
        else if (host.rx_valid || !in_frame)
            gap_cnt <= '0;
        else
            gap_cnt <= gap_cnt + 32'd1;
    end

    // A byte arriving on the expiry cycle still counts as in time.
    assign timeout = in_frame && !host.rx_valid && (gap_cnt == TIMEOUT_CYCLES - 1);
`else
    // No gap timer: a partial frame waits indefinitely.
    assign timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= ST_IDLE;
            op_rd       <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state <= state_n;
            if (op_ld)
                op_rd <= (host.rx_data == OP_RD);
            // The final byte is still on rx_data, so merge it directly
            // rather than waiting a cycle for the shifter.
            if (addr_ld)
                bus_addr_q <= {host.rx_data, rx_word[31:8]};
            if (wdata_ld)
                bus_wdata_q <= {host.rx_data, rx_word[31:8]};
        end
    end

    always_comb begin
        state_n   = state;
        frame_err = 1'b0;
        rx_shift  = 1'b0;
        tx_shift  = 1'b0;
        tx_load   = 1'b0;
        op_ld     = 1'b0;
        addr_ld   = 1'b0;
        wdata_ld  = 1'b0;
        tx_valid  = 1'b0;
        bus_we    = 1'b0;
        bus_re    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (host.rx_valid) begin
                    if (host.rx_data == OP_WR || host.rx_data == OP_RD) begin
                        op_ld   = 1'b1;
                        state_n = ST_ADDR;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (timeout) begin
                    frame_err = 1'b1;
                    state_n   = ST_IDLE;
                end else if (host.rx_valid) begin
                    rx_shift = 1'b1;
                    if (rx_cnt == 2'd3) begin
                        addr_ld = 1'b1;
                        state_n = op_rd ? ST_READ : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (timeout) begin
                    frame_err = 1'b1;
                    state_n   = ST_IDLE;
                end else if (host.rx_valid) begin
                    rx_shift = 1'b1;
                    if (rx_cnt == 2'd3) begin
                        wdata_ld = 1'b1;
                        state_n  = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                bus_we    = 1'b1;
                frame_err = host.rx_valid;
                state_n   = ST_IDLE;
            end
            ST_READ: begin
                bus_re    = 1'b1;
                frame_err = host.rx_valid;
                state_n   = ST_CAPT;
            end
            ST_CAPT: begin
                tx_load   = 1'b1;
                frame_err = host.rx_valid;
                state_n   = ST_RESP;
            end
            ST_RESP: begin
                tx_valid  = 1'b1;
                frame_err = host.rx_valid;
                if (host.tx_ready) begin
                    tx_shift = 1'b1;
                    if (tx_cnt == 2'd3)
                        state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Byte counters restart on every state change.
    assign seq_clr = (state_n != state);

    assign host.tx_data   = tx_word[7:0];
    assign host.tx_valid  = tx_valid;
    assign host.bus_addr  = bus_addr_q;
    assign host.bus_wdata = bus_wdata_q;
    assign host.bus_we    = bus_we;
    assign host.bus_re    = bus_re;
    assign busy           = (state != ST_IDLE);

endmodule
